// File: rtl/ysyx_23060337_isram_if.sv
// Fetch-side bus between the IFU (master) and the instruction SRAM responder
// (slave): a valid/ready request channel carrying a byte address, and a
// valid/ready response channel carrying the instruction word or an error flag.
interface ysyx_23060337_isram_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/ysyx_23060337_isram.sv
// Instruction SRAM responder. Accepts one word fetch at a time, answers after
// LATENCY cycles with the stored word or an error (misaligned / out of range),
// and holds the response until the fetch unit takes it. A side-band load port
// writes program images into the store at any time.
module ysyx_23060337_isram #(
    parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    ysyx_23060337_isram_if.slave    fetch,
    input  logic                    ld_en,
    input  logic [31:0]             ld_addr,
    input  logic [31:0]             ld_data
);
    localparam int          DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH) << 2;
    // WAIT counts down from here; unused when LATENCY = 1.
    localparam logic [3:0]  CNT_INIT   = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic [DEPTH_LOG2-1:0] r_index;
    logic                  r_err;
    logic [31:0]           r_resp_data;
    logic                  r_resp_err;
    logic [31:0]           r_mem [0:DEPTH-1];

    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_load_resp;
    logic [31:0]           w_req_off;
    logic                  w_req_err;
    logic [DEPTH_LOG2-1:0] w_req_index;
    logic [31:0]           w_ld_off;
    logic                  w_ld_err;
    logic [DEPTH_LOG2-1:0] w_ld_index;
    logic [DEPTH_LOG2-1:0] w_rd_index;
    logic                  w_rd_err;

    // Address decode: offsets wrap mod 2^32, so addresses below the base
    // land far out of range and are flagged without a separate compare.
    assign w_req_off   = fetch.req_addr - ADDR_BASE;
    assign w_req_err   = (fetch.req_addr[1:0] != 2'b00) || (w_req_off >= SPAN_BYTES);
    assign w_req_index = w_req_off[DEPTH_LOG2+1:2];
    assign w_ld_off    = ld_addr - ADDR_BASE;
    assign w_ld_err    = (ld_addr[1:0] != 2'b00) || (w_ld_off >= SPAN_BYTES);
    assign w_ld_index  = w_ld_off[DEPTH_LOG2+1:2];

    assign w_accept    = fetch.req_valid && w_req_ready;

    // The response register loads on the edge that enters RESP. With
    // LATENCY = 1 that is the acceptance edge itself, so the read must use
    // the live request address instead of the latched one.
    assign w_load_resp = ((r_state == S_WAIT) && (r_cnt == 4'd0)) ||
                         (w_accept && (LATENCY == 1));
    assign w_rd_index  = (r_state == S_WAIT) ? r_index : w_req_index;
    assign w_rd_err    = (r_state == S_WAIT) ? r_err   : w_req_err;

    // State register and wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic; a request accepted during a response handshake is
    // handled exactly like one accepted in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            S_IDLE, S_RESP: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_next = S_RESP;
                    end else begin
                        w_state_next = S_WAIT;
                        w_cnt_next   = CNT_INIT;
                    end
                end else if (r_state == S_RESP && fetch.resp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // Handshake outputs; a response being consumed frees the slot for a new request.
    always_comb begin
        w_req_ready      = rst && ((r_state == S_IDLE) ||
                                   ((r_state == S_RESP) && fetch.resp_ready));
        fetch.req_ready  = w_req_ready;
        fetch.resp_valid = (r_state == S_RESP);
        fetch.resp_data  = r_resp_data;
        fetch.resp_err   = r_resp_err;
    end

    // Latch the accepted request and capture the response word on RESP entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_index     <= '0;
            r_err       <= 1'b0;
            r_resp_data <= 32'd0;
            r_resp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_index <= w_req_index;
                r_err   <= w_req_err;
            end
            if (w_load_resp) begin
                r_resp_data <= w_rd_err ? 32'd0 : r_mem[w_rd_index];
                r_resp_err  <= w_rd_err;
            end
        end
    end

    // Preload writes; kept out of reset so the store survives it and the
    // response read on the same edge sees the old word.
    always_ff @(posedge clk) begin
        if (ld_en && !w_ld_err) begin
            r_mem[w_ld_index] <= ld_data;
        end
    end
endmodule

// File: tb/tb_ysyx_23060337_isram.sv
// Bench for the instruction SRAM responder: a LATENCY=2 instance carries most
// of the traffic, a LATENCY=1 instance covers single-cycle turnaround. Both
// share the clock, reset and preload port; a word-array model supplies every
// expected value.
module tb_ysyx_23060337_isram;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          WORDS = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = 32'd0;
    logic [31:0] ld_data = 32'd0;

    always #5 clk = ~clk;

    ysyx_23060337_isram_if bus2();
    ysyx_23060337_isram_if bus1();

    ysyx_23060337_isram #(.ADDR_BASE(BASE), .DEPTH_LOG2(12), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .fetch(bus2),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    ysyx_23060337_isram #(.ADDR_BASE(BASE), .DEPTH_LOG2(12), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .fetch(bus1),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] model_mem [0:WORDS-1];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic model_err(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] != 2'b00) || (off >= 32'(WORDS * 4));
    endfunction

    function automatic logic [31:0] model_data(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (model_err(a)) return 32'd0;
        return model_mem[off[13:2]];
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned sel;
        sel = $urandom_range(0, 9);
        if (sel < 6)       return BASE + 4 * $urandom_range(0, WORDS - 1);
        else if (sel == 6) return BASE + 4 * $urandom_range(0, WORDS - 1) + $urandom_range(1, 3);
        else if (sel == 7) return BASE + 32'h4000 + 4 * $urandom_range(0, 1000);
        else if (sel == 8) return BASE - 4 * $urandom_range(1, 1000);
        else               return $urandom;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        step();
        ld_en = 1'b0;
        off = a - BASE;
        if (!model_err(a)) model_mem[off[13:2]] = d;
    endtask

    // One complete fetch on the LATENCY=2 instance, with `stall` cycles of
    // response backpressure before the handshake.
    task automatic fetch2(input logic [31:0] a, input int stall);
        int          w;
        int          k;
        logic [31:0] held_data;
        logic        held_err;
        bus2.req_valid  = 1'b1;
        bus2.req_addr   = a;
        bus2.resp_ready = (stall == 0);
        w = 0;
        while (!bus2.req_ready && w < 50) begin
            step();
            w++;
        end
        if (!bus2.req_ready) begin
            check_eq("accept_timeout", {31'd0, bus2.req_ready}, 32'd1);
            bus2.req_valid = 1'b0;
            return;
        end
        step();
        bus2.req_valid = 1'b0;
        bus2.req_addr  = $urandom;
        k = 1;
        while (!bus2.resp_valid && k < 40) begin
            step();
            k++;
        end
        check_eq("latency", 32'(k), 32'd2);
        check_eq("resp_data", bus2.resp_data, model_data(a));
        check_eq("resp_err", {31'd0, bus2.resp_err}, {31'd0, model_err(a)});
        $display("[TB] fetch addr=%h data=%h err=%0d lat=%0d stall=%0d",
                 a, bus2.resp_data, bus2.resp_err, k, stall);
        held_data = bus2.resp_data;
        held_err  = bus2.resp_err;
        for (int i = 0; i < stall; i++) begin
            step();
            check_eq("bp_valid", {31'd0, bus2.resp_valid}, 32'd1);
            check_eq("bp_ready", {31'd0, bus2.req_ready}, 32'd0);
            check_eq("bp_data", bus2.resp_data, held_data);
            check_eq("bp_err", {31'd0, bus2.resp_err}, {31'd0, held_err});
        end
        bus2.resp_ready = 1'b1;
        step();
        check_eq("post_valid", {31'd0, bus2.resp_valid}, 32'd0);
        check_eq("post_ready", {31'd0, bus2.req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] old_word;
        logic [31:0] new_word;

        bus2.req_valid = 1'b0; bus2.req_addr = 32'd0; bus2.resp_ready = 1'b1;
        bus1.req_valid = 1'b0; bus1.req_addr = 32'd0; bus1.resp_ready = 1'b1;

        // Reset for three cycles.
        rst = 1'b0;
        repeat (3) step();
        check_eq("rst_valid2", {31'd0, bus2.resp_valid}, 32'd0);
        check_eq("rst_data2", bus2.resp_data, 32'd0);
        check_eq("rst_err2", {31'd0, bus2.resp_err}, 32'd0);
        check_eq("rst_valid1", {31'd0, bus1.resp_valid}, 32'd0);
        rst = 1'b1;
        #1;
        check_eq("rst_ready2", {31'd0, bus2.req_ready}, 32'd1);
        check_eq("rst_ready1", {31'd0, bus1.req_ready}, 32'd1);
        step();

        // Fill the whole store, then the directed program words.
        for (int i = 0; i < WORDS; i++) load_word(BASE + 32'(4 * i), $urandom);
        load_word(BASE, 32'h0000_0413);
        load_word(BASE + 32'd4, 32'h0010_0073);
        // These must be dropped: past the end, misaligned, below the base.
        load_word(BASE + 32'h4000, 32'hDEAD_0001);
        load_word(BASE + 32'd2, 32'hDEAD_0002);
        load_word(32'h7FFF_FFFC, 32'hDEAD_0003);

        fetch2(BASE, 0);
        fetch2(BASE + 32'd4, 0);

        // Back-to-back: second request accepted on the first response handshake.
        bus2.req_valid = 1'b1; bus2.req_addr = BASE; bus2.resp_ready = 1'b1;
        step();
        bus2.req_addr = BASE + 32'd4;
        check_eq("b2b_wait_valid", {31'd0, bus2.resp_valid}, 32'd0);
        check_eq("b2b_wait_ready", {31'd0, bus2.req_ready}, 32'd0);
        step();
        check_eq("b2b_r1_valid", {31'd0, bus2.resp_valid}, 32'd1);
        check_eq("b2b_r1_data", bus2.resp_data, 32'h0000_0413);
        check_eq("b2b_r1_ready", {31'd0, bus2.req_ready}, 32'd1);
        $display("[TB] b2b first  addr=%h data=%h", BASE, bus2.resp_data);
        step();
        bus2.req_valid = 1'b0;
        check_eq("b2b_gap_valid", {31'd0, bus2.resp_valid}, 32'd0);
        step();
        check_eq("b2b_r2_valid", {31'd0, bus2.resp_valid}, 32'd1);
        check_eq("b2b_r2_data", bus2.resp_data, 32'h0010_0073);
        $display("[TB] b2b second addr=%h data=%h", BASE + 32'd4, bus2.resp_data);
        step();
        check_eq("b2b_end_valid", {31'd0, bus2.resp_valid}, 32'd0);

        // Error cases.
        fetch2(BASE + 32'd2, 0);
        fetch2(BASE + 32'h4000, 0);
        fetch2(32'h7FFF_FFFC, 0);

        // Backpressure for five cycles.
        fetch2(BASE + 32'd8, 5);

        // Preload on the RESP-entry edge of the same word: old data returned.
        a = BASE + 32'd64;
        old_word = model_data(a);
        new_word = ~old_word;
        bus2.req_valid = 1'b1; bus2.req_addr = a; bus2.resp_ready = 1'b1;
        step();
        bus2.req_valid = 1'b0;
        ld_en = 1'b1; ld_addr = a; ld_data = new_word;
        step();
        ld_en = 1'b0;
        model_mem[16] = new_word;
        check_eq("rbw_valid", {31'd0, bus2.resp_valid}, 32'd1);
        check_eq("rbw_old_data", bus2.resp_data, old_word);
        $display("[TB] rbw addr=%h data=%h", a, bus2.resp_data);
        step();
        fetch2(a, 0);

        // Reset while in WAIT: no response ever appears.
        bus2.req_valid = 1'b1; bus2.req_addr = BASE + 32'd4; bus2.resp_ready = 1'b1;
        step();
        bus2.req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("rstw_valid", {31'd0, bus2.resp_valid}, 32'd0);
        step(); step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rstw_quiet", {31'd0, bus2.resp_valid}, 32'd0);
        end
        // Reset while holding a response under backpressure: it is dropped.
        bus2.req_valid = 1'b1; bus2.req_addr = BASE; bus2.resp_ready = 1'b0;
        step();
        bus2.req_valid = 1'b0;
        step();
        check_eq("rsth_valid_before", {31'd0, bus2.resp_valid}, 32'd1);
        rst = 1'b0;
        #1;
        check_eq("rsth_valid", {31'd0, bus2.resp_valid}, 32'd0);
        check_eq("rsth_data", bus2.resp_data, 32'd0);
        step(); step();
        rst = 1'b1;
        bus2.resp_ready = 1'b1;
        step();
        check_eq("rsth_quiet", {31'd0, bus2.resp_valid}, 32'd0);
        fetch2(BASE + 32'd4, 0);

        // Randomized traffic with occasional preloads between fetches.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) load_word(rand_addr(), $urandom);
            fetch2(rand_addr(), int'($urandom_range(0, 3)));
        end

        // LATENCY=1 instance: response the cycle after acceptance, one per cycle.
        bus1.resp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            a = (i == 0) ? BASE : rand_addr();
            bus1.req_addr  = a;
            bus1.req_valid = 1'b1;
            check_eq("l1_ready", {31'd0, bus1.req_ready}, 32'd1);
            step();
            check_eq("l1_valid", {31'd0, bus1.resp_valid}, 32'd1);
            check_eq("l1_data", bus1.resp_data, model_data(a));
            check_eq("l1_err", {31'd0, bus1.resp_err}, {31'd0, model_err(a)});
            $display("[TB] l1 fetch addr=%h data=%h err=%0d", a, bus1.resp_data, bus1.resp_err);
        end
        bus1.req_valid = 1'b0;
        step();
        check_eq("l1_end_valid", {31'd0, bus1.resp_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/ysyx_23060337_isram.md
Name: ysyx_23060337_isram

Overview:
- Instruction-memory responder: the slave end of the IFU fetch interface.
- Accepts one word-fetch request at a time on a valid/ready request channel. Returns the 32-bit instruction word, or an error, on a valid/ready response channel after a fixed, parameterised latency.
- Sits between the fetch unit and the instruction store.
- Has a side-band load port so the bench or boot logic can preload program images.

Parameters:
- ADDR_BASE, 32'h80000000, byte address of word 0; equals the PC reset vector.
- DEPTH_LOG2, 12, log2 of the number of 32-bit words stored (4096 words = 16 KiB).
- LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; 0 = in reset.
- req_valid  input  1  fetch request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_addr  input  32  byte address of the instruction.
- resp_valid  output  1  response present.
- resp_ready  input  1  fetch unit accepts the response.
- resp_data  output  32  instruction word; 0 when resp_err = 1.
- resp_err  output  1  request was misaligned or out of range.
- ld_en  input  1  preload write enable.
- ld_addr  input  32  preload byte address (same mapping as req_addr).
- ld_data  input  32  preload word.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, wait counter = 0.
  - resp_valid = 0, resp_data = 0, resp_err = 0, latched address = 0.
  - req_ready reflects IDLE (1) as soon as rst returns high.
  - Memory array is not cleared.
  - Reset in the middle of an operation drops any pending or held response with no handshake.
- Address map:
  - off = req_addr - ADDR_BASE, computed mod 2^32.
  - In range iff off < 4 * 2^DEPTH_LOG2. Addresses below ADDR_BASE wrap to a large off and are out of range.
  - Word index = off >> 2.
  - Misaligned iff req_addr[1:0] != 0.
  - err = misaligned OR out of range.
- States:
  - IDLE: req_ready = 1, resp_valid = 0.
    - On req_valid & req_ready: latch the index and err.
    - If LATENCY = 1, go to RESP. Otherwise go to WAIT with counter = LATENCY - 2.
  - WAIT: req_ready = 0.
    - If counter = 0, go to RESP. Otherwise decrement the counter.
  - Entering RESP:
    - resp_data = err ? 0 : mem[index]; resp_err = err.
    - Memory is read on the transition edge.
  - RESP: resp_valid = 1. resp_data and resp_err are held stable until resp_valid & resp_ready.
    - req_ready = resp_ready, so a new request can be accepted in the same cycle the response is consumed.
    - On the response handshake with a new request accepted: latch the new request and proceed exactly as from IDLE.
    - On the response handshake without a new request: go to IDLE and clear resp_valid.
- Latency: if a request is accepted at edge E, resp_valid is 1 in the cycle following edge E + (LATENCY - 1). LATENCY = 1 means the response is visible in the cycle right after acceptance.
- Throughput: with resp_ready held at 1, one response every LATENCY cycles.
- req_addr only needs to be valid in the acceptance cycle.
- Requests presented while req_ready = 0 are ignored. The requester must hold them (standard valid/ready rule).
- Preload port:
  - ld_en writes ld_data into mem[index(ld_addr)] at the clock edge, in any state.
  - Writes that are misaligned or out of range are silently dropped.
  - A preload write on the same edge as the RESP-entry read of the same word: the response carries the old data (read-before-write).
- Backpressure: resp_ready held at 0 keeps the responder in RESP indefinitely with outputs unchanged.

Test Plan:
- Reset then preload: rst = 0 for 3 cycles, release. Load 0x00000413 at 0x80000000 and 0x00100073 at 0x80000004. Fetch 0x80000000 with LATENCY = 2 and resp_ready = 1 -> resp_valid rises 2 cycles after acceptance, resp_data = 0x00000413, resp_err = 0.
- Back-to-back: req_valid held with addresses 0x80000000 then 0x80000004, resp_ready = 1 -> two responses 2 cycles apart, data 0x00000413 then 0x00100073. The second request is accepted in the same cycle the first response is consumed.
- Errors:
  - Fetch 0x80000002 -> resp_err = 1, resp_data = 0.
  - Fetch 0x80004000 (first word past the 16 KiB store) -> resp_err = 1.
  - Fetch 0x7FFFFFFC -> resp_err = 1.
- Backpressure: resp_ready = 0 for 5 cycles after resp_valid -> resp_valid, resp_data and resp_err stable, req_ready = 0. Raise resp_ready -> handshake occurs, state returns to IDLE, req_ready = 1.
- Reset mid-operation: assert rst = 0 while in WAIT -> resp_valid = 0 immediately with no response. After release, re-fetch 0x80000004 -> 0x00100073, since memory is retained.
- LATENCY = 1 build: fetch 0x80000000 -> resp_valid in the cycle right after acceptance. With resp_ready = 1, a new request is accepted every cycle.
